alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Single-cycle MIPS execute stage: ALU-control decode (aluop+funct -> 4-bit op), 32-bit ALU
//   (result, zero, overflow) and PC+4 incrementer. Sits between register file/immediate mux and
//   DM/writeback mux. All outputs registered: 1-cycle latency, sync reset.
// PARAMETERS
//   WIDTH      32   datapath width (in1, in2, result, pc_in, pc_plus4)
//   PC_STEP    4    PC increment constant
// PORTS
//   clk          input   1      rising-edge clock
//   rst          input   1      synchronous, active-high reset
//   in_valid     input   1      operands/controls valid this cycle
//   aluop        input   2      control-unit ALU op class
//   func         input   6      instruction funct field [5:0]
//   in1          input   WIDTH  operand A (rs data)
//   in2          input   WIDTH  operand B (rt data or sign-extended imm)
//   pc_in        input   WIDTH  current PC
//   out_valid    output  1      registered in_valid
//   aluctrl      output  4      registered decoded ALU op
//   result       output  WIDTH  registered ALU result
//   zero         output  1      registered (result == 0)
//   overflow     output  1      registered signed overflow (ADD/SUB only)
//   illegal_func output  1      registered: aluop=10 with unsupported funct
//   pc_plus4     output  WIDTH  registered pc_in + PC_STEP
// BEHAVIOUR
//   Decode (combinational):
//     aluop 00 -> ADD 0010 (lw/sw); 01 -> SUB 0110 (beq); 11 -> ADD 0010.
//     aluop 10 by funct: 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001;
//       100111 NOR 1100; 101010 SLT 0111; other -> ADD 0010 and illegal_func=1.
//   ALU ops: AND a&b; OR a|b; ADD a+b mod 2^32; SUB a-b mod 2^32; NOR ~(a|b);
//     SLT = 1 if $signed(a)<$signed(b) else 0 (zero-extended to WIDTH); any other code -> 0.
//   overflow: ADD: a,b same sign and sum sign differs; SUB: a,b differ in sign and diff sign
//     differs from a; 0 for all other ops. Results still wrap, no trap.
//   zero = (result == 0), computed on the final result (SLT false -> zero=1).
//   pc_plus4 = pc_in + PC_STEP mod 2^WIDTH (0xFFFFFFFC -> 0x00000000); independent of aluop.
//   Timing: posedge clk, rst=1 -> all outputs 0 (out_valid=0, aluctrl=0000, zero=0).
//     rst=0, in_valid=1 -> capture decode/ALU/pc results; out_valid=1 next cycle.
//     rst=0, in_valid=0 -> out_valid=0; data outputs hold previous values.
//   rst takes priority over in_valid; an operation presented with rst=1 is discarded.
//   No backpressure; a new operation may be issued every cycle (throughput 1/clk).
// TESTING
//   rst=1 one cycle with in_valid=1 -> next cycle all outputs 0, out_valid=0.
//   aluop=00,in1=7,in2=5,pc_in=0x100 -> result=12,zero=0,aluctrl=0010,pc_plus4=0x104.
//   aluop=01,in1=in2=0x1234 -> result=0,zero=1,aluctrl=0110; in1=3,in2=5 -> 0xFFFFFFFE.
//   aluop=10 funct AND/OR/NOR/SLT, in1=0xF0F0F0F0,in2=0x0FF00FF0 -> 0x00F000F0,
//     0xFFF0FFF0, 0x000F000F, 1 (negative < positive); SLT in1=5,in2=-1 -> 0,zero=1.
//   ADD 0x7FFFFFFF+1 -> 0x80000000,overflow=1; SUB 0x80000000-1 -> 0x7FFFFFFF,overflow=1;
//     pc_in=0xFFFFFFFC -> pc_plus4=0.
//   aluop=10,funct=000000 -> aluctrl=0010,illegal_func=1; in_valid=0 next -> out_valid=0, data held.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus: operands/controls in, registered results out.
//   master : issues operations (in_valid, aluop, func, in1, in2, pc_in), observes results
//   slave  : the execute unit; receives operations, drives out_valid, aluctrl, result,
//            zero, overflow, illegal_func, pc_plus4
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [1:0]       aluop;
  logic [5:0]       func;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] pc_in;
  logic             out_valid;
  logic [3:0]       aluctrl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal_func;
  logic [WIDTH-1:0] pc_plus4;

  modport master (
    output in_valid, aluop, func, in1, in2, pc_in,
    input  out_valid, aluctrl, result, zero, overflow, illegal_func, pc_plus4
  );

  modport slave (
    input  in_valid, aluop, func, in1, in2, pc_in,
    output out_valid, aluctrl, result, zero, overflow, illegal_func, pc_plus4
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-cycle MIPS execute stage: ALU-control decode, WIDTH-bit ALU with zero/overflow
// flags, and PC incrementer. Every output is registered (one cycle latency).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, takes priority over a valid operation
//   bus  : alu_exec_unit_if.slave carrying operation inputs and registered results
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PC_STEP = 4
) (
  input logic              clk,
  input logic              rst,
  alu_exec_unit_if.slave   bus
);

  localparam logic [3:0] CtlAnd = 4'b0000;
  localparam logic [3:0] CtlOr  = 4'b0001;
  localparam logic [3:0] CtlAdd = 4'b0010;
  localparam logic [3:0] CtlSub = 4'b0110;
  localparam logic [3:0] CtlSlt = 4'b0111;
  localparam logic [3:0] CtlNor = 4'b1100;

  logic [3:0]       ctl_d;
  logic             illegal_d;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic [WIDTH-1:0] result_d;
  logic             overflow_d;

  logic             out_valid_q;
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             illegal_q;
  logic [WIDTH-1:0] pc_plus4_q;

  // ALU-control decode
  always_comb begin
    ctl_d     = CtlAdd;
    illegal_d = 1'b0;
    unique case (bus.aluop)
      2'b00, 2'b11: ctl_d = CtlAdd;
      2'b01:        ctl_d = CtlSub;
      2'b10: begin
        case (bus.func)
          6'b100000: ctl_d = CtlAdd;
          6'b100010: ctl_d = CtlSub;
          6'b100100: ctl_d = CtlAnd;
          6'b100101: ctl_d = CtlOr;
          6'b100111: ctl_d = CtlNor;
          6'b101010: ctl_d = CtlSlt;
          default: begin
            ctl_d     = CtlAdd;
            illegal_d = 1'b1;
          end
        endcase
      end
      default: ctl_d = CtlAdd;
    endcase
  end

  assign sum  = bus.in1 + bus.in2;
  assign diff = bus.in1 - bus.in2;
  assign lt   = $signed(bus.in1) < $signed(bus.in2);

  // ALU datapath; overflow only meaningful for ADD/SUB, results always wrap
  always_comb begin
    result_d   = '0;
    overflow_d = 1'b0;
    case (ctl_d)
      CtlAnd: result_d = bus.in1 & bus.in2;
      CtlOr:  result_d = bus.in1 | bus.in2;
      CtlNor: result_d = ~(bus.in1 | bus.in2);
      CtlSlt: result_d = {{(WIDTH-1){1'b0}}, lt};
      CtlAdd: begin
        result_d   = sum;
        overflow_d = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      CtlSub: begin
        result_d   = diff;
        overflow_d = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                     (diff[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      default: result_d = '0;
    endcase
  end

  // Data outputs only update on a valid operation; otherwise they hold
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctl_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      pc_plus4_q  <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        ctl_q      <= ctl_d;
        result_q   <= result_d;
        zero_q     <= (result_d == '0);
        overflow_q <= overflow_d;
        illegal_q  <= illegal_d;
        pc_plus4_q <= bus.pc_in + WIDTH'(PC_STEP);
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.aluctrl      = ctl_q;
  assign bus.result       = result_q;
  assign bus.zero         = zero_q;
  assign bus.overflow     = overflow_q;
  assign bus.illegal_func = illegal_q;
  assign bus.pc_plus4     = pc_plus4_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: behavioural model checked every cycle plus
// directed literal expectations.
module tb_alu_exec_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(
    .WIDTH   (32),
    .PC_STEP (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected registered state
  bit          m_known;
  logic        m_valid;
  logic [3:0]  m_ctl;
  logic [31:0] m_res;
  logic        m_zero;
  logic        m_ov;
  logic        m_ill;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics from the instruction-level rules, using wide signed arithmetic
  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [3:0] ctl, output logic [31:0] res,
                                output logic ov, output logic ill);
    longint sa;
    longint sb;
    longint r;
    string  kind;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ill = 1'b0;
    if (op == 2'b01) kind = "sub";
    else if (op != 2'b10) kind = "add";
    else if (fn == 6'h20) kind = "add";
    else if (fn == 6'h22) kind = "sub";
    else if (fn == 6'h24) kind = "and";
    else if (fn == 6'h25) kind = "or";
    else if (fn == 6'h27) kind = "nor";
    else if (fn == 6'h2a) kind = "slt";
    else begin
      kind = "add";
      ill  = 1'b1;
    end
    ov = 1'b0;
    if (kind == "add") begin
      ctl = 4'd2;
      r   = sa + sb;
      res = r[31:0];
      ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end else if (kind == "sub") begin
      ctl = 4'd6;
      r   = sa - sb;
      res = r[31:0];
      ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end else if (kind == "and") begin
      ctl = 4'd0;
      res = a & b;
    end else if (kind == "or") begin
      ctl = 4'd1;
      res = a | b;
    end else if (kind == "nor") begin
      ctl = 4'd12;
      res = ~(a | b);
    end else begin
      ctl = 4'd7;
      res = (sa < sb) ? 32'd1 : 32'd0;
    end
  endfunction

  // Single compare process: advance model at each edge, check 1 time unit later
  initial begin
    m_known = 1'b0;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        m_known = 1'b1;
        m_valid = 1'b0;
        m_ctl   = '0;
        m_res   = '0;
        m_zero  = 1'b0;
        m_ov    = 1'b0;
        m_ill   = 1'b0;
        m_pc    = '0;
      end else if (bus.in_valid) begin
        model(bus.aluop, bus.func, bus.in1, bus.in2, m_ctl, m_res, m_ov, m_ill);
        m_valid = 1'b1;
        m_zero  = (m_res == 32'd0);
        m_pc    = bus.pc_in + 32'd4;
      end else begin
        m_valid = 1'b0;
      end
      #1;
      if (m_known) begin
        chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("cmp_aluctrl", 32'(bus.aluctrl), 32'(m_ctl));
        chk("cmp_result", bus.result, m_res);
        chk("cmp_zero", 32'(bus.zero), 32'(m_zero));
        chk("cmp_overflow", 32'(bus.overflow), 32'(m_ov));
        chk("cmp_illegal", 32'(bus.illegal_func), 32'(m_ill));
        chk("cmp_pc_plus4", bus.pc_plus4, m_pc);
      end
    end
  end

  // Drive one operation, let it be captured, then return 2 units after the edge
  task automatic issue(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    bus.in_valid = v;
    bus.aluop    = op;
    bus.func     = fn;
    bus.in1      = a;
    bus.in2      = b;
    bus.pc_in    = pc;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] corner [8];

  initial begin
    n_vec = 0;
    n_err = 0;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h7FFF_FFFF;
    corner[4] = 32'h8000_0000;
    corner[5] = 32'hFFFF_FFFC;
    corner[6] = 32'h8000_0001;
    corner[7] = 32'h7FFF_FFFE;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.aluop = 2'b00;
    bus.func = 6'd0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.pc_in = '0;
    @(posedge clk);
    #2;
    // Operation presented under reset is discarded
    issue(1'b1, 2'b00, 6'd0, 32'd9, 32'd9, 32'h40);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_aluctrl", 32'(bus.aluctrl), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_pc_plus4", bus.pc_plus4, 32'd0);
    rst = 1'b0;

    issue(1'b1, 2'b00, 6'd0, 32'd7, 32'd5, 32'h100);
    chk("lw_valid", 32'(bus.out_valid), 32'd1);
    chk("lw_result", bus.result, 32'd12);
    chk("lw_zero", 32'(bus.zero), 32'd0);
    chk("lw_aluctrl", 32'(bus.aluctrl), 32'b0010);
    chk("lw_pc_plus4", bus.pc_plus4, 32'h104);

    issue(1'b1, 2'b01, 6'd0, 32'h1234, 32'h1234, 32'h0);
    chk("beq_result", bus.result, 32'd0);
    chk("beq_zero", 32'(bus.zero), 32'd1);
    chk("beq_aluctrl", 32'(bus.aluctrl), 32'b0110);
    issue(1'b1, 2'b01, 6'd0, 32'd3, 32'd5, 32'h0);
    chk("beq_neg", bus.result, 32'hFFFF_FFFE);

    issue(1'b1, 2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);
    chk("and_result", bus.result, 32'h00F0_00F0);
    chk("and_aluctrl", 32'(bus.aluctrl), 32'b0000);
    issue(1'b1, 2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);
    chk("or_result", bus.result, 32'hFFF0_FFF0);
    issue(1'b1, 2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);
    chk("nor_result", bus.result, 32'h000F_000F);
    chk("nor_aluctrl", 32'(bus.aluctrl), 32'b1100);
    issue(1'b1, 2'b10, 6'b101010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0);
    chk("slt_true", bus.result, 32'd1);
    chk("slt_aluctrl", 32'(bus.aluctrl), 32'b0111);
    issue(1'b1, 2'b10, 6'b101010, 32'd5, 32'hFFFF_FFFF, 32'h0);
    chk("slt_false", bus.result, 32'd0);
    chk("slt_false_zero", 32'(bus.zero), 32'd1);

    issue(1'b1, 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFC);
    chk("add_ovf_result", bus.result, 32'h8000_0000);
    chk("add_ovf", 32'(bus.overflow), 32'd1);
    chk("pc_wrap", bus.pc_plus4, 32'd0);
    issue(1'b1, 2'b10, 6'b100010, 32'h8000_0000, 32'd1, 32'h0);
    chk("sub_ovf_result", bus.result, 32'h7FFF_FFFF);
    chk("sub_ovf", 32'(bus.overflow), 32'd1);

    issue(1'b1, 2'b10, 6'b000000, 32'd2, 32'd3, 32'h200);
    chk("illegal_aluctrl", 32'(bus.aluctrl), 32'b0010);
    chk("illegal_flag", 32'(bus.illegal_func), 32'd1);
    chk("illegal_result", bus.result, 32'd5);
    issue(1'b0, 2'b01, 6'b100100, 32'hDEAD_BEEF, 32'd1, 32'h300);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_hold_result", bus.result, 32'd5);
    chk("idle_hold_pc", bus.pc_plus4, 32'h204);
    chk("idle_hold_illegal", 32'(bus.illegal_func), 32'd1);

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h27;
        5: fn = 6'h2a;
        default: fn = 6'($urandom);
      endcase
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 9) == 0) b = a;
      rst = ($urandom_range(0, 39) == 0);
      issue($urandom_range(0, 4) != 0, 2'($urandom), fn, a, b,
            ($urandom_range(0, 7) == 0) ? corner[5] : $urandom);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
